// File: rtl/sine_lookup_q.sv
// Pipelined quarter-wave sine lookup with a channel tag carried alongside each sample.
// Define SINE_INTERP_EN to add the second lookup port and linear interpolation (latency 5, else 3).

module sine_lookup_q_port #(
  parameter int LUT_AW = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic [LUT_AW+1:0] idx,
  output logic [DATA_W-1:0] mag,
  output logic              neg
);
  localparam int DEPTH = 2 ** LUT_AW;

  // Entry k = round((2^DATA_W-1)*sin(pi/2*(k+0.5)/DEPTH)), built at elaboration from a Taylor series.
  function automatic logic [DATA_W-1:0] quarter_sine(input int k);
    real x, term, acc;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(DEPTH);
    term = x;
    acc  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return DATA_W'($rtoi(acc * real'((2 ** DATA_W) - 1) + 0.5));
  endfunction

  logic [DATA_W-1:0] rom_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [DATA_W-1:0] ENTRY = quarter_sine(g);
    assign rom_tab[g] = ENTRY;
  end

  logic [LUT_AW-1:0] addr_q;
  logic [1:0]        neg_q;

  always_ff @(posedge clk) begin
    addr_q   <= idx[LUT_AW] ? ~idx[LUT_AW-1:0] : idx[LUT_AW-1:0];
    neg_q[0] <= idx[LUT_AW+1];
    neg_q[1] <= neg_q[0];
    mag      <= rom_tab[addr_q];
  end

  assign neg = neg_q[1];

endmodule

module sine_lookup_q #(
  parameter int LUT_AW    = 9,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int TAG_W     = 4,
  parameter     INIT_FILE = "sine_quarter.hex",
  localparam int PHASE_W  = LUT_AW + 2 + FRAC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PHASE_W-1:0]       in_phase,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  output logic [TAG_W-1:0]         out_tag,
  output logic signed [DATA_W:0]   sine_out
);
  localparam int IW = LUT_AW + 2;
`ifdef SINE_INTERP_EN
  localparam int STAGES = 5;
  localparam int NPORT  = 2;
`else
  localparam int STAGES = 3;
  localparam int NPORT  = 1;
`endif

  function automatic logic signed [DATA_W:0] apply_sign(input logic [DATA_W-1:0] m, input logic n);
    logic signed [DATA_W:0] v;
    v = $signed({1'b0, m});
    return n ? -v : v;
  endfunction

  logic [STAGES:1]                 vld_pipe;
  logic [STAGES-1:1][TAG_W-1:0]    tag_pipe;
  logic [IW-1:0]                   idx;
  logic [NPORT-1:0][IW-1:0]        port_idx;
  logic [NPORT-1:0][DATA_W-1:0]    port_mag;
  logic [NPORT-1:0]                port_neg;

  // The table file is kept as a parameter for drop-in compatibility; contents come from elaboration.
  logic unused_init;
  assign unused_init = ^INIT_FILE;

  assign idx       = in_phase[PHASE_W-1:FRAC_W];
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    tag_pipe <= {tag_pipe[STAGES-2:1], in_tag};
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    sine_lookup_q_port #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_port (
      .clk (clk),
      .idx (port_idx[p]),
      .mag (port_mag[p]),
      .neg (port_neg[p])
    );
  end

`ifdef SINE_INTERP_EN
  localparam int PW = DATA_W + FRAC_W + 3;

  logic [3:1][FRAC_W-1:0]   frac_pipe;
  logic signed [DATA_W:0]   s0_q, s1_q, s0_d;
  logic signed [DATA_W+1:0] diff;
  logic signed [PW-1:0]     prod_q;

  // Port B wraps modulo the full period, so 0x7FF interpolates toward index 0.
  assign port_idx = {idx + IW'(1), idx};
  assign diff     = (DATA_W+2)'(s1_q) - (DATA_W+2)'(s0_q);

  always_ff @(posedge clk) begin
    frac_pipe <= {frac_pipe[2:1], in_phase[FRAC_W-1:0]};
    s0_q      <= apply_sign(port_mag[0], port_neg[0]);
    s1_q      <= apply_sign(port_mag[1], port_neg[1]);
    s0_d      <= s0_q;
    prod_q    <= PW'(diff) * PW'($signed({1'b0, frac_pipe[3]}));
  end

  // Result lies between s0 and s1, so wrapping to DATA_W+1 bits is exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      sine_out <= '0;
      out_tag  <= '0;
    end else if (vld_pipe[4]) begin
      sine_out <= s0_d + (DATA_W+1)'(prod_q >>> FRAC_W);
      out_tag  <= tag_pipe[4];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^in_phase[FRAC_W-1:0];
  assign port_idx    = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      sine_out <= '0;
      out_tag  <= '0;
    end else if (vld_pipe[2]) begin
      sine_out <= apply_sign(port_mag[0], port_neg[0]);
      out_tag  <= tag_pipe[2];
    end
  end
`endif

endmodule

// File: tb/tb_sine_lookup_q.sv
// Scoreboard bench for sine_lookup_q; expected values come from a real-valued sine model.
module tb_sine_lookup_q;
  localparam int LUT_AW  = 9;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int TAG_W   = 4;
  localparam int PHASE_W = LUT_AW + 2 + FRAC_W;
  localparam int NIDX    = 1 << (LUT_AW + 2);
  localparam int DEPTH   = 1 << LUT_AW;
`ifdef SINE_INTERP_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef struct { int cyc; int tag; int val; } rec_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic [PHASE_W-1:0]     in_phase = '0;
  logic [TAG_W-1:0]       in_tag = '0;
  logic                   out_valid;
  logic [TAG_W-1:0]       out_tag;
  logic signed [DATA_W:0] sine_out;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   cap_en = 1'b0;
  int   lut [DEPTH];
  rec_t exp_q[$];
  rec_t got_q[$];

  sine_lookup_q #(.LUT_AW(LUT_AW), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W),
                  .INIT_FILE("sine_quarter.hex")) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_phase(in_phase), .in_tag(in_tag),
    .out_valid(out_valid), .out_tag(out_tag), .sine_out(sine_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (cap_en && out_valid === 1'b1) got_q.push_back('{cyc, int'(out_tag), int'(sine_out)});

  function automatic int sgn(input int i);
    int q, k, a;
    i = i & (NIDX - 1);
    q = i >> LUT_AW;
    k = i & (DEPTH - 1);
    a = (q & 1) ? (DEPTH - 1 - k) : k;
    return (q & 2) ? -lut[a] : lut[a];
  endfunction

  function automatic int model(input int i, input int f);
`ifdef SINE_INTERP_EN
    int s0, s1, p;
    s0 = sgn(i);
    s1 = sgn(i + 1);
    p  = (s1 - s0) * f;
    return s0 + (p >>> FRAC_W);
`else
    return sgn(i + 0 * f);
`endif
  endfunction

  task automatic send(input int idx, input int frac, input int tag, input int expv);
    @(negedge clk);
    in_valid = 1'b1;
    in_phase = PHASE_W'((idx << FRAC_W) | frac);
    in_tag   = TAG_W'(tag);
    exp_q.push_back('{cyc, tag, expv});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_tag = 4'hA; in_phase = PHASE_W'(300 << FRAC_W);
    repeat (4) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (sine_out !== '0) begin bad++; $display("FAIL rst_sine: got %0d want 0", sine_out); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL rst_tag: got %0d want 0", out_tag); end
    reset = 1'b0; in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid: got %b want 0", out_valid); end
    cap_en = 1'b1;
  endtask

  task automatic test_symmetry;
    rec_t e, g;
    send(12'h000, 0, 0, lut[0]);
    send(12'h1FF, 0, 1, lut[DEPTH-1]);
    send(12'h200, 0, 2, lut[DEPTH-1]);
    send(12'h400, 0, 3, -lut[0]);
    send(12'h600, 0, 4, -lut[DEPTH-1]);
    idle(LAT + 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL sym_missing: got none want tag %0d", e.tag); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val || g.tag !== e.tag || g.cyc !== e.cyc + LAT) begin
          bad++;
          $display("FAIL sym: got val=%0d tag=%0d cyc=%0d want val=%0d tag=%0d cyc=%0d",
                   g.val, g.tag, g.cyc, e.val, e.tag, e.cyc + LAT);
        end
      end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL sym_extra: got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_full_period;
    rec_t e, g;
    int outv [NIDX];
    for (int i = 0; i < NIDX; i++) send(i, 0, i % 16, model(i, 0));
    idle(LAT + 3);
    for (int i = 0; i < NIDX; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin bad++; outv[i] = 0; $display("FAIL full_missing: got none want idx %0d", i); end
      else begin
        g = got_q.pop_front();
        outv[i] = g.val;
        if (g.val !== e.val || g.tag !== e.tag || g.cyc !== e.cyc + LAT) begin
          bad++;
          $display("FAIL full idx %0d: got val=%0d tag=%0d cyc=%0d want val=%0d tag=%0d cyc=%0d",
                   i, g.val, g.tag, g.cyc, e.val, e.tag, e.cyc + LAT);
        end
      end
    end
    for (int i = 0; i < NIDX / 2; i++) begin
      total++;
      if (outv[i] !== -outv[i + NIDX / 2]) begin
        bad++; $display("FAIL half_antisym idx %0d: got %0d want %0d", i, outv[i + NIDX / 2], -outv[i]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (outv[i] !== outv[2 * DEPTH - 1 - i]) begin
        bad++; $display("FAIL mirror idx %0d: got %0d want %0d", i, outv[2 * DEPTH - 1 - i], outv[i]);
      end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL full_extra: got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_stream_tags;
    rec_t e, g;
    int idx, frac;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) idle(2);
      idx  = (i * 37 + 5) % NIDX;
      frac = int'($urandom_range(0, 255));
      send(idx, frac, i % 16, model(idx, frac));
    end
    idle(LAT + 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL stream_missing: got none want tag %0d", e.tag); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val || g.tag !== e.tag || g.cyc !== e.cyc + LAT) begin
          bad++;
          $display("FAIL stream: got val=%0d tag=%0d cyc=%0d want val=%0d tag=%0d cyc=%0d",
                   g.val, g.tag, g.cyc, e.val, e.tag, e.cyc + LAT);
        end
      end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL stream_extra: got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_fraction;
    rec_t e, g;
`ifdef SINE_INTERP_EN
    send(12'h000, 8'h80, 1, lut[0] + (((lut[1] - lut[0]) * 128) >>> 8));
    send(12'h7FF, 8'h80, 2, 0);
`else
    send(5, 8'hFF, 3, lut[5]);
`endif
    idle(LAT + 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL frac_missing: got none want tag %0d", e.tag); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val || g.tag !== e.tag || g.cyc !== e.cyc + LAT) begin
          bad++;
          $display("FAIL frac: got val=%0d tag=%0d cyc=%0d want val=%0d tag=%0d cyc=%0d",
                   g.val, g.tag, g.cyc, e.val, e.tag, e.cyc + LAT);
        end
      end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL frac_extra: got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_mid;
    int want;
    cap_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_phase = PHASE_W'((100 + 50 * i) << FRAC_W); in_tag = TAG_W'(7 + i);
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_phase = PHASE_W'(900 << FRAC_W); in_tag = 4'd9;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; in_phase = PHASE_W'(12'h080 << FRAC_W); in_tag = 4'd5;
    want = model(12'h080, 0);
    for (int c = 0; c < LAT; c++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid c%0d: got %b want 0", c, out_valid); end
      total++; if (sine_out !== '0) begin bad++; $display("FAIL midrst_sine c%0d: got %0d want 0", c, sine_out); end
      total++; if (out_tag !== '0) begin bad++; $display("FAIL midrst_tag c%0d: got %0d want 0", c, out_tag); end
      @(negedge clk);
      in_valid = 1'b0;
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_first_valid: got %b want 1", out_valid); end
    total++; if (int'(sine_out) !== want) begin bad++; $display("FAIL midrst_first_sine: got %0d want %0d", sine_out, want); end
    total++; if (out_tag !== 4'd5) begin bad++; $display("FAIL midrst_first_tag: got %0d want 5", out_tag); end
    idle(LAT + 2);
    cap_en = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++)
      lut[k] = $rtoi(65535.0 * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(DEPTH)) + 0.5);
    test_reset();
    test_symmetry();
    test_full_period();
    test_stream_tags();
    test_fraction();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_lookup_q.md
# sine_lookup_q

Parametrised, pipelined quarter-wave sine lookup for the synth engine oscillators. It stores only the first quarter of one sine period and rebuilds the full period from two symmetries. It accepts one phase word per clock from a time-multiplexed voice/channel stream. A channel tag travels through the pipeline with each sample, so the downstream mixer can re-associate results. Optional linear interpolation between adjacent table entries uses the phase fraction bits.

## Interface
Parameters:
- LUT_AW, 9: quarter-table address width; the table holds 2^LUT_AW entries.
- DATA_W, 16: unsigned magnitude width of the table entries.
- FRAC_W, 8: phase fraction bits below the table index.
- TAG_W, 4: channel tag width.
- INIT_FILE, "sine_quarter.hex": table contents.
- Derived parameter PHASE_W = LUT_AW+2+FRAC_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  phase word present this cycle.
- in_phase  in  PHASE_W  unsigned phase, one full period = 2^PHASE_W.
- in_tag  in  TAG_W  channel number of this sample.
- out_valid  out  1  sine_out/out_tag valid this cycle.
- out_tag  out  TAG_W  tag of the sample on sine_out.
- sine_out  out  DATA_W+1  signed two's-complement sine value.

## Operation
- Integer index I = in_phase[PHASE_W-1:FRAC_W] (LUT_AW+2 bits); fraction F = in_phase[FRAC_W-1:0].
- Quadrant q = I[LUT_AW+1:LUT_AW]; k = I[LUT_AW-1:0].
- Table entry k holds round((2^DATA_W-1)*sin(pi/2*(k+0.5)/2^LUT_AW)).
  - The half-sample offset makes bitwise mirroring exact.
- First symmetry: table address = q[0] ? ~k : k.
- Second symmetry: value = q[1] ? -{1'b0,mag} : {1'b0,mag}.
  - A magnitude of 0 always yields +0, never negative zero.
- The table is synchronous ROM with a registered output: 2-cycle read, like the existing block RAMs.
- With interpolation compiled in:
  - Port A reads index I and port B reads index I+1 mod 2^(LUT_AW+2), so the wrap from 0x7FF to 0x000 crosses into quadrant 0.
  - Both reads get their own symmetry: s0 and s1.
  - d = s1-s0, signed DATA_W+2 bits.
  - p = d*{1'b0,F}, signed.
  - sine_out = s0 + (p >>> FRAC_W); the arithmetic shift rounds toward -inf.
  - The result always lies between s0 and s1, so no saturation is needed.
- No backpressure: the block is a fixed-latency streaming pipeline.
  - in_valid may be high every cycle.
  - Gaps in in_valid propagate as gaps in out_valid.
- in_valid, in_tag and the quadrant bits are delay-matched through every stage.
- When out_valid is low, sine_out and out_tag hold their last value.

## Timing
- Latency without interpolation: 3 cycles from in_valid sampled to out_valid.
  - Stage 1: address/mirror register.
  - Stages 2–3: ROM read plus sign register.
- Latency with interpolation: 5 cycles.
  - Stages 1–3 as above for both ports.
  - Stage 4: d and p.
  - Stage 5: add and output register.
- Throughput: 1 sample per clock in both configurations.
- Reset:
  - Clears every valid stage and drives out_valid=0, sine_out=0, out_tag=0.
  - In-flight samples are discarded, including on reset mid-stream.
  - The first input after reset is accepted on the cycle reset is low.
  - out_valid stays low until that sample reaches the output.
- Simultaneous reset and in_valid: reset wins; the sample is dropped.

## Configuration
- SINE_INTERP_EN defined:
  - Dual-port ROM and interpolation stages are instantiated.
  - Latency is 5.
  - F is used.
- SINE_INTERP_EN undefined:
  - Single-port ROM only.
  - F is ignored (truncation to the index).
  - Latency is 3.
  - No multiplier is inferred.

## Test plan
- Symmetry sweep: apply I=0, I=0x1FF, I=0x200, I=0x400 and I=0x600 with F=0.
  - Required: sine_out = +LUT[0], +LUT[511], +LUT[511], -LUT[0] and -LUT[511] respectively.
- Full-period sweep: apply all 2048 indices with F=0.
  - Required: out[i] = -out[i+1024] for all i, and out[i] = out[1023-i] for i<512.
- Streaming tags: in_valid high continuously, tags 0..15 repeating, in_valid deasserted for 2 cycles mid-stream.
  - Required: out_tag sequence identical to the input sequence, delayed exactly 3 cycles (5 with SINE_INTERP_EN).
  - Required: a matching 2-cycle out_valid gap.
- Interpolation (SINE_INTERP_EN only): apply I=0, F=0x80.
  - Required: sine_out = LUT[0] + ((LUT[1]-LUT[0])*128 >>> 8).
  - Wrap case: I=0x7FF, F=0x80 -> sine_out = 0.
- Reset mid-operation: assert reset for 1 cycle while 3 samples are in flight.
  - Required: out_valid=0, sine_out=0 and out_tag=0 from the cycle after reset until the first post-reset sample emerges at full latency.
- Truncation (SINE_INTERP_EN undefined): apply I=5 with F=0xFF.
  - Required: sine_out = +LUT[5].
